// File: rtl/hazard_pkg.sv
// Shared types and encodings for the ID-stage branch hazard/forwarding controller.
//   REG_W    : GPR number width
//   kind_e   : producer kind held in the scoreboard (ALU result or load data)
//   FWD_*    : comparator operand forwarding selects
//   COND_*   : branch condition codes carried on d_cond
//   sb_entry_t : one scoreboard entry {valid, dst, kind}
package hazard_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned COND_W = 3;

    typedef enum logic {
        KIND_ALU  = 1'b0,
        KIND_LOAD = 1'b1
    } kind_e;

    localparam logic [SEL_W-1:0] FWD_RF = 2'b00;
    localparam logic [SEL_W-1:0] FWD_M  = 2'b01;
    localparam logic [SEL_W-1:0] FWD_W  = 2'b10;

    localparam logic [COND_W-1:0] COND_BEQ  = 3'b000;
    localparam logic [COND_W-1:0] COND_BNE  = 3'b001;
    localparam logic [COND_W-1:0] COND_BLEZ = 3'b010;
    localparam logic [COND_W-1:0] COND_BGTZ = 3'b011;
    localparam logic [COND_W-1:0] COND_BLTZ = 3'b100;
    localparam logic [COND_W-1:0] COND_BGEZ = 3'b101;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dst;
        kind_e            kind;
    } sb_entry_t;

endpackage

// File: rtl/hazard_operand_chk.sv
// Per-operand hazard check against the E/M/W scoreboard.
//   reg_num   : source register read by the branch compare
//   used      : operand is actually read by the compare
//   e_ent/m_ent/w_ent : scoreboard entries
//   stall_req : operand value not yet obtainable by forwarding
//   sel       : forwarding select (FWD_RF / FWD_M / FWD_W)
module hazard_operand_chk
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] reg_num,
    input  logic             used,
    input  sb_entry_t        e_ent,
    input  sb_entry_t        m_ent,
    input  sb_entry_t        w_ent,
    output logic             stall_req,
    output logic [SEL_W-1:0] sel
);

    logic active;
    logic e_hit;
    logic m_hit;
    logic w_hit;

    // r0 is hardwired zero, so it never depends on anything in flight
    assign active = used && (reg_num != '0);
    assign e_hit  = e_ent.valid && (e_ent.dst == reg_num);
    assign m_hit  = m_ent.valid && (m_ent.dst == reg_num);
    assign w_hit  = w_ent.valid && (w_ent.dst == reg_num);

    // E results are never ready in ID; M load data arrives only at W
    always_comb begin
        stall_req = 1'b0;
        sel       = FWD_RF;
        if (active) begin
            stall_req = e_hit || (m_hit && (m_ent.kind == KIND_LOAD));
            if (m_hit && (m_ent.kind == KIND_ALU)) begin
                sel = FWD_M;
            end else if (w_hit) begin
                sel = FWD_W;
            end
        end
    end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Hazard and forwarding controller for the ID-stage branch comparator.
// Keeps a three-entry E/M/W scoreboard of in-flight GPR writes and derives
// the rs/rt forwarding selects, the decode stall and branch-taken.
//   clk, rst_n          : clock, async active-low reset
//   d_*                 : D-stage instruction fields
//   e_flush             : kill the instruction entering E
//   zero/equal/less/more: comparator flags
//   zero_rs_trans/zero_rt_trans : forwarding selects (combinational)
//   stall, branch_taken : combinational control to PC mux / D-E register
//   stall_cycles        : saturating count of stall cycles
module branch_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_valid,
    input  logic [REG_W-1:0]  d_rs,
    input  logic [REG_W-1:0]  d_rt,
    input  logic              d_use_rs,
    input  logic              d_use_rt,
    input  logic              d_is_branch,
    input  logic [COND_W-1:0] d_cond,
    input  logic              d_wen,
    input  logic [REG_W-1:0]  d_dst,
    input  logic              d_kind,
    input  logic              e_flush,
    input  logic              zero,
    input  logic              equal,
    input  logic              less,
    input  logic              more,
    output logic [SEL_W-1:0]  zero_rs_trans,
    output logic [SEL_W-1:0]  zero_rt_trans,
    output logic              stall,
    output logic              branch_taken,
    output logic [CNT_W-1:0]  stall_cycles
);

    sb_entry_t        e_q;
    sb_entry_t        m_q;
    sb_entry_t        w_q;
    sb_entry_t        e_d;
    logic [CNT_W-1:0] cnt_q;
    logic             rs_stall;
    logic             rt_stall;
    logic             cond_met;

    hazard_operand_chk u_rs_chk (
        .reg_num   (d_rs),
        .used      (d_use_rs),
        .e_ent     (e_q),
        .m_ent     (m_q),
        .w_ent     (w_q),
        .stall_req (rs_stall),
        .sel       (zero_rs_trans)
    );

    hazard_operand_chk u_rt_chk (
        .reg_num   (d_rt),
        .used      (d_use_rt),
        .e_ent     (e_q),
        .m_ent     (m_q),
        .w_ent     (w_q),
        .stall_req (rt_stall),
        .sel       (zero_rt_trans)
    );

    assign stall = d_valid && d_is_branch && (rs_stall || rt_stall);

    // Entry that enters E: a bubble unless D really writes a nonzero GPR and advances
    always_comb begin
        e_d = '0;
        if (d_valid && d_wen && (d_dst != '0) && !stall && !e_flush) begin
            e_d.valid = 1'b1;
            e_d.dst   = d_dst;
            e_d.kind  = kind_e'(d_kind);
        end
    end

    // Branch condition decode
    always_comb begin
        cond_met = 1'b0;
        case (d_cond)
            COND_BEQ:  cond_met = equal;
            COND_BNE:  cond_met = !equal;
            COND_BLEZ: cond_met = less || zero;
            COND_BGTZ: cond_met = more;
            COND_BLTZ: cond_met = less;
            COND_BGEZ: cond_met = !less;
            default:   cond_met = 1'b0;
        endcase
    end

    // rst_n gating keeps the PC from redirecting while the pipeline is held in reset
    assign branch_taken = rst_n && d_valid && d_is_branch && !stall && cond_met;

    // Scoreboard shift and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            w_q <= m_q;
            m_q <= e_q;
            e_q <= e_d;
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed self-checking bench for branch_hazard_ctrl.
module tb_branch_hazard_ctrl;
    import hazard_pkg::*;

    localparam int unsigned CNT_W = 16;

    logic              clk;
    logic              rst_n;
    logic              d_valid;
    logic [REG_W-1:0]  d_rs;
    logic [REG_W-1:0]  d_rt;
    logic              d_use_rs;
    logic              d_use_rt;
    logic              d_is_branch;
    logic [COND_W-1:0] d_cond;
    logic              d_wen;
    logic [REG_W-1:0]  d_dst;
    logic              d_kind;
    logic              e_flush;
    logic              zero;
    logic              equal;
    logic              less;
    logic              more;
    logic [SEL_W-1:0]  zero_rs_trans;
    logic [SEL_W-1:0]  zero_rt_trans;
    logic              stall;
    logic              branch_taken;
    logic [CNT_W-1:0]  stall_cycles;

    int checks;
    int failures;

    branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .d_valid       (d_valid),
        .d_rs          (d_rs),
        .d_rt          (d_rt),
        .d_use_rs      (d_use_rs),
        .d_use_rt      (d_use_rt),
        .d_is_branch   (d_is_branch),
        .d_cond        (d_cond),
        .d_wen         (d_wen),
        .d_dst         (d_dst),
        .d_kind        (d_kind),
        .e_flush       (e_flush),
        .zero          (zero),
        .equal         (equal),
        .less          (less),
        .more          (more),
        .zero_rs_trans (zero_rs_trans),
        .zero_rt_trans (zero_rt_trans),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Check every combinational output plus the counter in one call
    task automatic check_all(input string tag, input logic exp_stall, input logic [1:0] exp_rs,
                             input logic [1:0] exp_rt, input logic exp_taken, input int exp_cnt);
        check({tag, ".stall"}, 32'(stall), 32'(exp_stall));
        check({tag, ".rs_sel"}, 32'(zero_rs_trans), 32'(exp_rs));
        check({tag, ".rt_sel"}, 32'(zero_rt_trans), 32'(exp_rt));
        check({tag, ".taken"}, 32'(branch_taken), 32'(exp_taken));
        check({tag, ".cnt"}, 32'(stall_cycles), 32'(exp_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic d_idle();
        d_valid = 1'b0; d_rs = '0; d_rt = '0; d_use_rs = 1'b0; d_use_rt = 1'b0;
        d_is_branch = 1'b0; d_cond = '0; d_wen = 1'b0; d_dst = '0; d_kind = 1'b0;
        e_flush = 1'b0;
    endtask

    task automatic d_prod(input logic [4:0] dst, input logic kind);
        d_idle();
        d_valid = 1'b1; d_wen = 1'b1; d_dst = dst; d_kind = kind;
    endtask

    task automatic d_br(input logic [2:0] cond, input logic [4:0] rs, input logic [4:0] rt,
                        input logic use_rs, input logic use_rt);
        d_idle();
        d_valid = 1'b1; d_is_branch = 1'b1; d_cond = cond;
        d_rs = rs; d_rt = rt; d_use_rs = use_rs; d_use_rt = use_rt;
    endtask

    task automatic flags(input logic z, input logic eq, input logic lt, input logic gt);
        zero = z; equal = eq; less = lt; more = gt;
    endtask

    // Reset pulse released mid-cycle; returns shortly after the release
    task automatic do_reset();
        d_idle();
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        flags(1'b0, 1'b1, 1'b0, 1'b0);

        // Reset held: dependent-looking branch that also writes its own source
        rst_n = 1'b0;
        d_br(COND_BEQ, 5'd1, 5'd1, 1'b1, 1'b1);
        d_wen = 1'b1; d_dst = 5'd1;
        step();
        step();
        check_all("rst_hold", 1'b0, FWD_RF, FWD_RF, 1'b0, 0);

        // ALU r5 then BEQ r5,r0: one stall, then M forwarding
        do_reset();
        d_prod(5'd5, KIND_ALU);
        step();
        d_br(COND_BEQ, 5'd5, 5'd0, 1'b1, 1'b1);
        flags(1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check_all("alu_c1", 1'b1, FWD_RF, FWD_RF, 1'b0, 0);
        step();
        check_all("alu_c2", 1'b0, FWD_M, FWD_RF, 1'b1, 1);
        equal = 1'b0;
        #1;
        check("alu_c2_neq.taken", 32'(branch_taken), 32'd0);

        // LW r8 then BNE r8,r9: two stalls, then W forwarding
        do_reset();
        d_prod(5'd8, KIND_LOAD);
        step();
        d_br(COND_BNE, 5'd8, 5'd9, 1'b1, 1'b1);
        flags(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_all("lw_c1", 1'b1, FWD_RF, FWD_RF, 1'b0, 0);
        step();
        check_all("lw_c2", 1'b1, FWD_RF, FWD_RF, 1'b0, 1);
        step();
        check_all("lw_c3", 1'b0, FWD_W, FWD_RF, 1'b1, 2);

        // Writes to r0 never create a dependency
        do_reset();
        d_prod(5'd0, KIND_ALU);
        step();
        d_prod(5'd0, KIND_LOAD);
        step();
        d_br(COND_BEQ, 5'd0, 5'd0, 1'b1, 1'b1);
        flags(1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check_all("r0", 1'b0, FWD_RF, FWD_RF, 1'b1, 0);

        // r3 in both M and W: M wins
        do_reset();
        d_prod(5'd3, KIND_ALU);
        step();
        d_prod(5'd3, KIND_ALU);
        step();
        d_idle();
        step();
        d_br(COND_BGEZ, 5'd3, 5'd0, 1'b1, 1'b0);
        flags(1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check_all("prio", 1'b0, FWD_M, FWD_RF, 1'b0, 0);
        less = 1'b0;
        #1;
        check("prio_ge.taken", 32'(branch_taken), 32'd1);

        // Unused rt that matches E must not stall; flushed producer leaves E empty
        do_reset();
        d_prod(5'd6, KIND_ALU);
        e_flush = 1'b1;
        step();
        d_br(COND_BEQ, 5'd6, 5'd0, 1'b1, 1'b0);
        flags(1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check_all("flush", 1'b0, FWD_RF, FWD_RF, 1'b1, 0);
        d_prod(5'd7, KIND_ALU);
        step();
        d_br(3'b110, 5'd1, 5'd7, 1'b1, 1'b0);
        #1;
        check_all("unused_rt", 1'b0, FWD_RF, FWD_RF, 1'b0, 0);

        // LW r4, BLTZ r4, reset pulse during the first stall cycle
        do_reset();
        d_prod(5'd4, KIND_LOAD);
        step();
        d_br(COND_BLTZ, 5'd4, 5'd0, 1'b1, 1'b0);
        flags(1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("midrst_pre.stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all("midrst_in", 1'b0, FWD_RF, FWD_RF, 1'b0, 0);
        rst_n = 1'b1;
        step();
        check_all("midrst_post", 1'b0, FWD_RF, FWD_RF, 1'b1, 0);
        less = 1'b0;
        #1;
        check("midrst_post_ge.taken", 32'(branch_taken), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
